// File: rtl/mastermind_pkg.sv
// Shared types and sizing for the Mastermind guess scoring engine.
package mastermind_pkg;

  localparam int unsigned NUM_DIGITS  = 4;
  localparam int unsigned DIGIT_W     = 2;
  localparam int unsigned MAX_GUESSES = 10;
  localparam int unsigned COUNT_MAX   = 99;

  localparam int unsigned CODE_W  = NUM_DIGITS * DIGIT_W;
  localparam int unsigned COUNT_W = 7;
  localparam int unsigned ACC_W   = 3;
  localparam int unsigned IDX_W   = 2;

  typedef logic [DIGIT_W-1:0]         digit_t;
  typedef digit_t [NUM_DIGITS-1:0]    code_t;
  typedef logic [NUM_DIGITS-1:0]      mark_t;

  typedef enum logic [2:0] {
    IDLE,
    EXACT,
    PARTIAL,
    DONE,
    OVER
  } scorer_state_t;

endpackage

// File: rtl/partial_match_finder.sv
// Finds the highest-index unmarked code digit equal to the target digit.
module partial_match_finder
  import mastermind_pkg::*;
(
  input  digit_t           i_target,
  input  code_t            i_code,
  input  mark_t            i_cmark,
  output logic             o_hit_c,
  output logic [IDX_W-1:0] o_idx_c
);

  // Ascending scan so the last (highest) eligible index wins.
  always_comb begin
    o_hit_c = 1'b0;
    o_idx_c = '0;
    for (int j = 0; j < int'(NUM_DIGITS); j++) begin
      if (!i_cmark[j] && (i_code[j] == i_target)) begin
        o_hit_c = 1'b1;
        o_idx_c = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/guess_scorer.sv
// Multi-cycle Mastermind scorer: exact pass, four partial-match passes, then
// registered results, guess counting and sticky win/loss for the display.
module guess_scorer
  import mastermind_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enter,
  input  logic [CODE_W-1:0]    guess,
  input  logic [CODE_W-1:0]    code,
  input  logic                 real_game,
  output logic                 busy,
  output logic                 score_valid,
  output logic [ACC_W-1:0]     correct_loc,
  output logic [ACC_W-1:0]     value_only,
  output logic [COUNT_W-1:0]   guess_count,
  output logic                 won,
  output logic                 lost
);

  scorer_state_t       r_state;
  scorer_state_t       w_state_nxt;

  logic                r_enter_q;
  code_t               r_g;
  code_t               r_c;
  mark_t               r_gmark;
  mark_t               r_cmark;
  logic [IDX_W-1:0]    r_idx;
  logic [ACC_W-1:0]    r_cl_acc;
  logic [ACC_W-1:0]    r_vo_acc;

  logic                r_busy;
  logic                r_score_valid;
  logic [ACC_W-1:0]    r_correct_loc;
  logic [ACC_W-1:0]    r_value_only;
  logic [COUNT_W-1:0]  r_guess_count;
  logic                r_won;
  logic                r_lost;

  logic                w_submit;
  logic                w_load;
  logic                w_exact;
  logic                w_partial;
  logic                w_finish;
  logic                w_release;

  mark_t               w_exact_vec;
  logic [ACC_W-1:0]    w_exact_cnt;
  logic                w_find_hit;
  logic [IDX_W-1:0]    w_find_idx;
  logic                w_partial_hit;
  logic [ACC_W-1:0]    w_vo_final;
  logic [COUNT_W-1:0]  w_cnt_next;
  logic                w_win;
  logic                w_lose;

  assign w_submit = enter & ~r_enter_q;

  // Previous key level; reset high so a key held through reset is ignored.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_enter_q <= 1'b1;
    else        r_enter_q <= enter;
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and per-phase strobes; results are loaded on the edge into DONE.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_exact     = 1'b0;
    w_partial   = 1'b0;
    w_finish    = 1'b0;
    w_release   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_submit) begin
          w_load      = 1'b1;
          w_state_nxt = EXACT;
        end
      end
      EXACT: begin
        w_exact     = 1'b1;
        w_state_nxt = PARTIAL;
      end
      PARTIAL: begin
        w_partial = 1'b1;
        if (r_idx == '0) begin
          w_finish    = 1'b1;
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_release   = 1'b1;
        w_state_nxt = (r_won || r_lost) ? OVER : IDLE;
      end
      OVER: begin
        w_state_nxt = OVER;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Exact-position match vector and its population count.
  always_comb begin
    w_exact_vec = '0;
    w_exact_cnt = '0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      w_exact_vec[i] = (r_g[i] == r_c[i]);
      w_exact_cnt    = w_exact_cnt + ACC_W'(w_exact_vec[i]);
    end
  end

  partial_match_finder u_finder (
    .i_target (r_g[r_idx]),
    .i_code   (r_c),
    .i_cmark  (r_cmark),
    .o_hit_c  (w_find_hit),
    .o_idx_c  (w_find_idx)
  );

  assign w_partial_hit = w_find_hit & ~r_gmark[r_idx];
  assign w_vo_final    = r_vo_acc + ACC_W'(w_partial_hit);
  assign w_cnt_next    = (r_guess_count >= COUNT_W'(COUNT_MAX)) ?
                         COUNT_W'(COUNT_MAX) : (r_guess_count + COUNT_W'(1));
  assign w_win         = (r_cl_acc == ACC_W'(NUM_DIGITS));
  assign w_lose        = ~w_win & real_game &
                         (w_cnt_next >= COUNT_W'(MAX_GUESSES));

  // Scoring datapath: operand latch, marks, digit index and accumulators.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_g      <= '0;
      r_c      <= '0;
      r_gmark  <= '0;
      r_cmark  <= '0;
      r_idx    <= '0;
      r_cl_acc <= '0;
      r_vo_acc <= '0;
    end else if (w_load) begin
      r_g      <= code_t'(guess);
      r_c      <= code_t'(code);
      r_gmark  <= '0;
      r_cmark  <= '0;
      r_idx    <= '0;
      r_cl_acc <= '0;
      r_vo_acc <= '0;
    end else if (w_exact) begin
      r_gmark  <= w_exact_vec;
      r_cmark  <= w_exact_vec;
      r_cl_acc <= w_exact_cnt;
      r_idx    <= IDX_W'(NUM_DIGITS - 1);
    end else if (w_partial) begin
      if (w_partial_hit) r_cmark[w_find_idx] <= 1'b1;
      r_vo_acc <= w_vo_final;
      r_idx    <= r_idx - IDX_W'(1);
    end
  end

  // Registered results, guess count and sticky game outcome.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy        <= 1'b0;
      r_score_valid <= 1'b0;
      r_correct_loc <= '0;
      r_value_only  <= '0;
      r_guess_count <= '0;
      r_won         <= 1'b0;
      r_lost        <= 1'b0;
    end else begin
      r_score_valid <= w_finish;
      if (w_load)         r_busy <= 1'b1;
      else if (w_release) r_busy <= 1'b0;
      if (w_finish) begin
        r_correct_loc <= r_cl_acc;
        r_value_only  <= w_vo_final;
        r_guess_count <= w_cnt_next;
        r_won         <= r_won | w_win;
        r_lost        <= r_lost | w_lose;
      end
    end
  end

  assign busy        = r_busy;
  assign score_valid = r_score_valid;
  assign correct_loc = r_correct_loc;
  assign value_only  = r_value_only;
  assign guess_count = r_guess_count;
  assign won         = r_won;
  assign lost        = r_lost;

endmodule

// File: tb/tb_guess_scorer.sv
// Directed self-checking bench for guess_scorer.
module tb_guess_scorer;

  logic       clk;
  logic       reset;
  logic       enter;
  logic [7:0] guess;
  logic [7:0] code;
  logic       real_game;
  logic       busy;
  logic       score_valid;
  logic [2:0] correct_loc;
  logic [2:0] value_only;
  logic [6:0] guess_count;
  logic       won;
  logic       lost;

  int n_assert = 0;
  int n_fail   = 0;

  guess_scorer dut (
    .clk         (clk),
    .reset       (reset),
    .enter       (enter),
    .guess       (guess),
    .code        (code),
    .real_game   (real_game),
    .busy        (busy),
    .score_valid (score_valid),
    .correct_loc (correct_loc),
    .value_only  (value_only),
    .guess_count (guess_count),
    .won         (won),
    .lost        (lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One press; observes 12 cycles: first pulse latency, pulse count, busy per cycle.
  // again>0 re-presses the key at that cycle (while the scorer is busy).
  task automatic press(input int again, output int lat, output int npulse,
                       output logic [11:0] bmask);
    @(negedge clk);
    enter  = 1'b1;
    lat    = -1;
    npulse = 0;
    bmask  = '0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) enter = 1'b0;
      if (again > 0 && k == again)     enter = 1'b1;
      if (again > 0 && k == again + 1) enter = 1'b0;
      bmask[k-1] = busy;
      if (score_valid) begin
        npulse++;
        if (lat < 0) lat = k;
      end
    end
  endtask

  task automatic score(input string tag, input logic [7:0] g,
                       input int e_cl, input int e_vo, input int e_cnt);
    int lat, np;
    logic [11:0] bm;
    guess = g;
    press(0, lat, np, bm);
    check({tag, "_latency"}, lat, 6);
    check({tag, "_correct_loc"}, correct_loc, e_cl);
    check({tag, "_value_only"}, value_only, e_vo);
    check({tag, "_guess_count"}, guess_count, e_cnt);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int lat, np, pulses, seen_busy;
    logic [11:0] bm;

    reset     = 1'b0;
    enter     = 1'b1;
    guess     = '0;
    code      = '0;
    real_game = 1'b0;

    // Reset held with key pressed, released with key still held.
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_count", guess_count, 0);
    reset     = 1'b1;
    pulses    = 0;
    seen_busy = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (score_valid) pulses++;
      if (busy) seen_busy++;
    end
    enter = 1'b0;
    check("held_key_pulses", pulses, 0);
    check("held_key_busy", seen_busy, 0);
    check("held_key_count", guess_count, 0);
    check("held_key_won", won, 0);
    check("held_key_lost", lost, 0);

    // Practice mode scoring; first press also checks busy window N+1..N+6.
    code  = 8'b00_01_10_11;
    guess = 8'b11_10_01_00;
    press(0, lat, np, bm);
    check("perm_latency", lat, 6);
    check("perm_pulses", np, 1);
    check("perm_busy_window", bm, 12'h03F);
    check("perm_correct_loc", correct_loc, 0);
    check("perm_value_only", value_only, 4);
    check("perm_count", guess_count, 1);

    code = 8'b01_01_10_10;
    score("dup_1111", 8'b01_01_01_01, 2, 0, 2);
    score("dup_2211", 8'b10_10_01_01, 0, 4, 3);
    score("dup_1233", 8'b01_10_11_11, 1, 1, 4);

    // Second press while busy is dropped.
    guess = 8'b01_01_01_01;
    press(3, lat, np, bm);
    check("busy_drop_pulses", np, 1);
    check("busy_drop_latency", lat, 6);
    check("busy_drop_count", guess_count, 5);
    check("busy_drop_cl", correct_loc, 2);

    // Reset asserted at N+3 aborts scoring.
    @(negedge clk);
    enter = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (k == 1) enter = 1'b0;
    end
    reset = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_valid", score_valid, 0);
    check("abort_cl", correct_loc, 0);
    check("abort_vo", value_only, 0);
    check("abort_count", guess_count, 0);
    repeat (2) @(negedge clk);
    reset  = 1'b1;
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (score_valid) pulses++;
    end
    check("abort_no_pulse", pulses, 0);

    // Real game: ten non-winning guesses lose on the tenth.
    real_game = 1'b1;
    code      = 8'b00_01_10_11;
    for (int n = 1; n <= 9; n++) begin
      guess = 8'b00_00_00_00;
      press(0, lat, np, bm);
    end
    check("loss_9_count", guess_count, 9);
    check("loss_9_lost", lost, 0);
    score("loss_10", 8'b00_00_00_00, 1, 0, 10);
    check("loss_10_lost", lost, 1);
    check("loss_10_won", won, 0);
    press(0, lat, np, bm);
    check("loss_11_pulses", np, 0);
    check("loss_11_count", guess_count, 10);
    check("loss_11_busy", bm, 12'h000);

    // Win on the tenth (final) guess: won, not lost, then frozen.
    do_reset();
    for (int n = 1; n <= 9; n++) begin
      guess = 8'b00_00_00_00;
      press(0, lat, np, bm);
    end
    score("win_10", 8'b00_01_10_11, 4, 0, 10);
    check("win_10_won", won, 1);
    check("win_10_lost", lost, 0);
    guess = 8'b00_00_00_00;
    press(0, lat, np, bm);
    check("win_after_pulses", np, 0);
    check("win_after_count", guess_count, 10);
    check("win_after_cl", correct_loc, 4);

    // Practice mode saturates at 99 with no loss; switching to real then loses.
    do_reset();
    real_game = 1'b0;
    guess     = 8'b00_00_00_00;
    for (int n = 1; n <= 100; n++) press(0, lat, np, bm);
    check("sat_count", guess_count, 99);
    check("sat_lost", lost, 0);
    check("sat_won", won, 0);
    real_game = 1'b1;
    score("late_real", 8'b00_00_00_00, 1, 0, 99);
    check("late_real_lost", lost, 1);
    check("late_real_won", won, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/guess_scorer.md
Name: guess_scorer

Overview:
- Sequential scoring and round-control engine for the Mastermind codebreaker, directly upstream of the hex display mux.
- Accepts a 4-digit guess on a push-button press and scores it against the secret code with duplicate-safe Mastermind rules.
- Scores over several cycles using per-digit mark bits.
- Maintains the guess count and the win/lose state, and produces registered results for the display stage.

Parameters:
- NUM_DIGITS, 4, digits per code; fixed by the top level.
- DIGIT_W, 2, bits per digit (values 0-3).
- MAX_GUESSES, 10, guesses allowed in a real game before loss.
- COUNT_MAX, 99, saturation value of guess_count (two hex digits).

Ports:
- clk  in  1  divided system clock.
- reset  in  1  asynchronous, active-low; block is in reset while reset==0.
- enter  in  1  level, high while submit key held; already inverted from the key, not debounced.
- guess  in  8  {d3,d2,d1,d0}, 2 bits each, from switches.
- code  in  8  secret code {d3,d2,d1,d0}; stable during scoring.
- real_game  in  1  1 = limited game, 0 = practice.
- busy  out  1  scoring in progress.
- score_valid  out  1  one-cycle pulse when new results are presented.
- correct_loc  out  3  exact matches, 0-4.
- value_only  out  3  right value, wrong place, 0-4.
- guess_count  out  7  guesses scored, saturating at COUNT_MAX.
- won  out  1  sticky win flag.
- lost  out  1  sticky loss flag.

Behaviour:
- Reset (async, reset==0):
  - State IDLE.
  - All outputs 0.
  - enter_q set to 1, so a key held through reset release is not a submission.
  - All marks cleared.
- Edge detect: submit = enter & ~enter_q, with enter_q registered every cycle.
  - Submissions are honoured only in IDLE.
  - Submissions in any other state are dropped, not queued.
- FSM states:
  - IDLE: on submit, latch guess and code into g_r/c_r, clear marks, go to EXACT. busy=1 from the next cycle.
  - EXACT (1 cycle): for each i, if g_r[i]==c_r[i], set gmark[i] and cmark[i] and increment cl_acc. Go to PARTIAL with idx=3.
  - PARTIAL (4 cycles, idx 3..0):
    - If gmark[idx]==0, find the highest-index j with cmark[j]==0 and c_r[j]==g_r[idx].
    - If found, set cmark[j] and increment vo_acc.
    - Decrement idx. After idx==0, go to DONE.
  - DONE (1 cycle):
    - Register correct_loc=cl_acc and value_only=vo_acc.
    - Update guess_count = min(guess_count+1, COUNT_MAX).
    - Pulse score_valid.
    - If cl_acc==4, set won.
    - Otherwise, if real_game==1 and the new guess_count >= MAX_GUESSES, set lost.
    - Next state is OVER if won or lost, else IDLE.
  - OVER: busy=0. All submissions ignored. Outputs frozen. Exit only by reset.
- Latency:
  - Submit sampled in cycle N.
  - score_valid high in cycle N+6.
  - All result outputs change in that same cycle.
  - busy is high N+1..N+6.
- Simultaneity and boundaries:
  - A win on the final allowed guess sets won, not lost.
  - won and lost are never both 1.
  - real_game is sampled only in DONE. Switching to practice mid-game prevents a later loss. Switching to real at or past MAX_GUESSES causes loss on the next non-winning guess.
  - In practice mode guess_count saturates at 99 with no loss.
  - Reset asserted mid-scoring aborts immediately to the reset state. No score_valid is produced.
  - Accumulators are 3-bit; cl_acc + vo_acc <= 4 always.

Decomposition:
- Package mastermind_pkg holds:
  - NUM_DIGITS, DIGIT_W, MAX_GUESSES, COUNT_MAX.
  - digit_t (logic [1:0]).
  - code_t (digit_t array [3:0]).
  - enum scorer_state_t {IDLE, EXACT, PARTIAL, DONE, OVER}.
- Sub-module: partial_match_finder, combinational.
  - Inputs: target digit, code_t, cmark.
  - Outputs: hit and 2-bit index j (highest unmarked match).
  - Used once per PARTIAL cycle.

Test Plan:
- Reset held with enter=1, then released -> no score_valid; guess_count=0, won=0, lost=0.
- code {0,1,2,3}, guess {3,2,1,0}, one press -> score_valid at N+6; correct_loc=0, value_only=4, guess_count=1.
- code {1,1,2,2}, guess {1,1,1,1} -> correct_loc=2, value_only=0. Guess {2,2,1,1} -> 0/4. Guess {1,2,3,3} -> 1/1.
- real_game=1, 10 non-winning presses -> lost=1 on the 10th score_valid; an 11th press leaves guess_count=10.
- Winning guess as the 10th in a real game -> won=1, lost=0, state OVER; further presses ignored.
- Second press during busy -> dropped, single score_valid. Reset asserted at N+3 -> outputs 0, no pulse.
